checkout_engine: RTL
====================

CHECKOUT_ENGINE -- requirements
Module: checkout_engine

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DIGITS, 2: decimal display digits per field.
- TW, 7: binary width of every total; TW SHALL be large enough to hold 10^DIGITS-1.
- DEB, 64: debounce hold time in cycles.
- COIN0, 5: value added by key[0].
- COIN1, 1: value added by key[1].
- COIN2, 10: value added by key[2].
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clock, in, 1: clock. Reset clr_n, asynchronous, active-low; clock clock.
- clr_n, in, 1: asynchronous active-low reset.
- key, in, 3: active-low coin buttons, asynchronous to clock.
- item_valid, in, 1: one-cycle strobe that adds item_price to the item total.
- item_price, in, TW: binary item price.
- clear, in, 1: one-cycle strobe that zeroes both totals.
- IRsig, in, 1: presence sensor input.
- seg_pay, out, 7*DIGITS: active-low 7-segment digits for the paid total.
- seg_item, out, 7*DIGITS: active-low 7-segment digits for the item total.
- seg_chg, out, 7*DIGITS: active-low 7-segment digits for change.
- busy, out, 1: BCD conversion in progress.
- ovf, out, 1: a total has saturated.
- short, out, 1: paid total is less than item total.
- lightup, out, 1: registered copy of IRsig.

Function
REQ-003 Each key bit SHALL use a two-flop synchroniser followed by a counter that reloads to DEB on every sampled change and decrements to 0; when the counter reaches 1 the level SHALL be latched, and a latched 1->0 transition SHALL produce a one-cycle press pulse.
REQ-004 A press pulse on key[i] SHALL add COINi to pay_total in the following cycle; simultaneous presses SHALL add the sum of their coin values in that one cycle.
REQ-005 item_valid SHALL add item_price to item_total in the following cycle; a coin press and an item_valid in the same cycle SHALL both be applied.
REQ-006 Either total that would exceed MAX = 10^DIGITS-1 SHALL saturate at MAX and set ovf; ovf SHALL be sticky until clear or reset.
REQ-007 clear SHALL zero pay_total and item_total and drop ovf and short; clear SHALL take priority over any coin or item event in the same cycle.
REQ-008 chg SHALL be pay_total - item_total when pay_total >= item_total, otherwise 0 with short = 1; short SHALL update in the same cycle as the totals.
REQ-009 The converter FSM SHALL have the states IDLE, LOAD, SHIFT, STORE and SHALL convert pay, item and chg in that order.
- Each value SHALL use double-dabble: 1 LOAD cycle, TW SHIFT cycles, 1 STORE cycle.
- A full pass SHALL take exactly 3*(TW+2) cycles.
REQ-010 A change to any total SHALL set a dirty flag.
- In IDLE with dirty set, the FSM SHALL clear dirty and start a pass on the next cycle.
- dirty set during a pass SHALL cause one additional pass immediately after STORE of chg.
REQ-011 busy SHALL be 1 in every state other than IDLE.
REQ-012 The seg_* outputs SHALL update only in STORE, so the displays never show partially converted digits.
REQ-013 Segment codes SHALL be the active-low patterns gfedcba:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
REQ-014 When ovf = 1, every digit of seg_pay and seg_item SHALL show F (0001110); when short = 1, every digit of seg_chg SHALL show F.
REQ-015 lightup SHALL equal IRsig delayed by one clock.

Reset
REQ-016 While clr_n = 0, all of the following SHALL hold:
- totals = 0; dirty, ovf, short, busy, lightup = 0.
- FSM in IDLE; debounce counters = 0; latched key levels = 1.
- All seg_* digits = 1000000.
REQ-017 Reset asserted mid-pass SHALL abort the pass; after release the first conversion SHALL start only on a new event.

Verification
REQ-018 With DEB=64, press key[0] for 200 cycles -> exactly one press pulse, pay_total = 5, seg_pay = "05" after 27 cycles of busy.
REQ-019 key[2] bouncing every 10 cycles for 100 cycles and then held low -> exactly one +10, no pulse during the bounce.
REQ-020 Pay 15, then item_valid with price 12 -> chg = 3, short = 0; a further item of 5 -> short = 1, seg_chg = "FF".
REQ-021 Coins totalling 95, then press key[2] -> pay_total = 99, ovf = 1, seg_pay = "FF"; clear -> all displays "00", ovf = 0.
REQ-022 item_valid during a busy pass -> exactly one extra pass (busy continuously high for 54 cycles), final values correct.
REQ-023 Assert clr_n low during SHIFT -> busy = 0 and displays "00" immediately; IRsig = 1 -> lightup = 1 one cycle later.

Source files
------------

// File: rtl/checkout_engine.sv
// Checkout engine: debounced coin keys build a paid total, item strobes build
// an item total, and a double-dabble converter refreshes three 7-segment
// fields (paid, item, change) whenever either total moves.
// Digit 0 of every seg_* field is the least-significant decimal digit.

// Per-key debouncer: synchronise, hold-off counter, latched level, press pulse.
module checkout_debounce #(
   parameter int DEB = 64
) (
   input  logic clock,
   input  logic clr_n,
   input  logic key_i,
   output logic press_o
);
   localparam int CW = $clog2(DEB + 1);

   logic [1:0]    sync_q;
   logic          samp_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          lvl_q, lvl_d;
   logic          press_q, press_d;

   // Reload on any sampled change, count down otherwise; latch the level
   // once the input has been quiet for the full hold time.
   always_comb begin
      cnt_d   = cnt_q;
      lvl_d   = lvl_q;
      press_d = 1'b0;
      if (sync_q[1] != samp_q) begin
         cnt_d = CW'(DEB);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
      if (cnt_q == CW'(1) && sync_q[1] == samp_q) begin
         lvl_d   = samp_q;
         press_d = lvl_q & ~samp_q;
      end
   end

   // Synchroniser, sample history and debounce state; keys idle high.
   always_ff @(posedge clock or negedge clr_n) begin
      if (!clr_n) begin
         sync_q  <= 2'b11;
         samp_q  <= 1'b1;
         cnt_q   <= '0;
         lvl_q   <= 1'b1;
         press_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], key_i};
         samp_q  <= sync_q[1];
         cnt_q   <= cnt_d;
         lvl_q   <= lvl_d;
         press_q <= press_d;
      end
   end

   assign press_o = press_q;
endmodule

module checkout_engine #(
   parameter int DIGITS = 2,
   parameter int TW     = 7,
   parameter int DEB    = 64,
   parameter int COIN0  = 5,
   parameter int COIN1  = 1,
   parameter int COIN2  = 10
) (
   input  logic                clock,
   input  logic                clr_n,
   input  logic [2:0]          key,
   input  logic                item_valid,
   input  logic [TW-1:0]       item_price,
   input  logic                clear,
   input  logic                IRsig,
   output logic [7*DIGITS-1:0] seg_pay,
   output logic [7*DIGITS-1:0] seg_item,
   output logic [7*DIGITS-1:0] seg_chg,
   output logic                busy,
   output logic                ovf,
   output logic                short,
   output logic                lightup
);
   localparam int MAX = 10**DIGITS - 1;
   localparam int BW  = 4 * DIGITS;
   localparam int SW  = $clog2(TW + 1);
   localparam logic [7*DIGITS-1:0] SEG_F    = {DIGITS{7'b0001110}};
   localparam logic [7*DIGITS-1:0] SEG_ZERO = {DIGITS{7'b1000000}};

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} state_t;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = 7'b0001110;
      endcase
   endfunction

   logic [2:0]          press;
   logic [31:0]         coin_sum, pay_sum, item_sum;
   logic [TW-1:0]       pay_q, pay_d, item_q, item_d, chg;
   logic                ovf_q, ovf_d, short_q, short_d, dirty_q, dirty_d;
   logic                changed, lightup_q;
   state_t              st_q, st_d;
   logic [1:0]          sel_q, sel_d;
   logic [SW-1:0]       sh_q, sh_d;
   logic [TW-1:0]       bin_q, bin_d;
   logic [BW-1:0]       bcd_q, bcd_d, bcd_adj;
   logic [7*DIGITS-1:0] seg_dig;
   logic [7*DIGITS-1:0] seg_pay_q, seg_pay_d, seg_item_q, seg_item_d, seg_chg_q, seg_chg_d;

   for (genvar g = 0; g < 3; g++) begin : g_key
      checkout_debounce #(.DEB(DEB)) u_db (
         .clock   (clock),
         .clr_n   (clr_n),
         .key_i   (key[g]),
         .press_o (press[g])
      );
   end

   // Next totals: coins and item add together, saturate at MAX, clear wins.
   always_comb begin
      coin_sum = 32'd0;
      if (press[0]) coin_sum = coin_sum + 32'(COIN0);
      if (press[1]) coin_sum = coin_sum + 32'(COIN1);
      if (press[2]) coin_sum = coin_sum + 32'(COIN2);
      pay_sum  = 32'(pay_q) + coin_sum;
      item_sum = 32'(item_q) + (item_valid ? 32'(item_price) : 32'd0);
      pay_d    = pay_q;
      item_d   = item_q;
      ovf_d    = ovf_q;
      if (clear) begin
         pay_d  = '0;
         item_d = '0;
         ovf_d  = 1'b0;
      end else begin
         if (pay_sum > 32'(MAX)) begin
            pay_d = TW'(MAX);
            ovf_d = 1'b1;
         end else begin
            pay_d = pay_sum[TW-1:0];
         end
         if (item_sum > 32'(MAX)) begin
            item_d = TW'(MAX);
            ovf_d  = 1'b1;
         end else begin
            item_d = item_sum[TW-1:0];
         end
      end
      short_d = (pay_d < item_d);
      changed = (pay_d != pay_q) | (item_d != item_q) | (ovf_d != ovf_q) | (short_d != short_q);
      chg     = (pay_q >= item_q) ? (pay_q - item_q) : '0;
   end

   // Double-dabble correction (+3 on digits >= 5) and segment decode of the BCD.
   always_comb begin
      bcd_adj = bcd_q;
      seg_dig = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         seg_dig[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
      end
   end

   // Converter FSM: pay, item, chg each get LOAD, TW x SHIFT, STORE.
   always_comb begin
      st_d       = st_q;
      sel_d      = sel_q;
      sh_d       = sh_q;
      bin_d      = bin_q;
      bcd_d      = bcd_q;
      dirty_d    = dirty_q | changed;
      seg_pay_d  = seg_pay_q;
      seg_item_d = seg_item_q;
      seg_chg_d  = seg_chg_q;
      case (st_q)
         IDLE: begin
            if (dirty_q) begin
               dirty_d = changed;
               sel_d   = 2'd0;
               st_d    = LOAD;
            end
         end
         LOAD: begin
            case (sel_q)
               2'd0:    bin_d = pay_q;
               2'd1:    bin_d = item_q;
               default: bin_d = chg;
            endcase
            bcd_d = '0;
            sh_d  = '0;
            st_d  = SHIFT;
         end
         SHIFT: begin
            bcd_d = BW'({bcd_adj, bin_q[TW-1]});
            bin_d = bin_q << 1;
            sh_d  = sh_q + 1'b1;
            if (sh_q == SW'(TW - 1)) st_d = STORE;
         end
         STORE: begin
            case (sel_q)
               2'd0:    seg_pay_d  = ovf_q   ? SEG_F : seg_dig;
               2'd1:    seg_item_d = ovf_q   ? SEG_F : seg_dig;
               default: seg_chg_d  = short_q ? SEG_F : seg_dig;
            endcase
            if (sel_q == 2'd2) begin
               sel_d = 2'd0;
               if (dirty_q) begin
                  dirty_d = changed;
                  st_d    = LOAD;
               end else begin
                  st_d = IDLE;
               end
            end else begin
               sel_d = sel_q + 1'b1;
               st_d  = LOAD;
            end
         end
         default: st_d = IDLE;
      endcase
   end

   // All state; reset aborts any pass and drops pending work.
   always_ff @(posedge clock or negedge clr_n) begin
      if (!clr_n) begin
         pay_q      <= '0;
         item_q     <= '0;
         ovf_q      <= 1'b0;
         short_q    <= 1'b0;
         dirty_q    <= 1'b0;
         st_q       <= IDLE;
         sel_q      <= 2'd0;
         sh_q       <= '0;
         bin_q      <= '0;
         bcd_q      <= '0;
         seg_pay_q  <= SEG_ZERO;
         seg_item_q <= SEG_ZERO;
         seg_chg_q  <= SEG_ZERO;
         lightup_q  <= 1'b0;
      end else begin
         pay_q      <= pay_d;
         item_q     <= item_d;
         ovf_q      <= ovf_d;
         short_q    <= short_d;
         dirty_q    <= dirty_d;
         st_q       <= st_d;
         sel_q      <= sel_d;
         sh_q       <= sh_d;
         bin_q      <= bin_d;
         bcd_q      <= bcd_d;
         seg_pay_q  <= seg_pay_d;
         seg_item_q <= seg_item_d;
         seg_chg_q  <= seg_chg_d;
         lightup_q  <= IRsig;
      end
   end

   assign seg_pay  = seg_pay_q;
   assign seg_item = seg_item_q;
   assign seg_chg  = seg_chg_q;
   assign busy     = (st_q != IDLE);
   assign ovf      = ovf_q;
   assign short    = short_q;
   assign lightup  = lightup_q;
endmodule
